// File: rtl/qpsk_demod.sv
// Coherent QPSK demodulator: fs/4 mixing, integrate-and-dump slicing, 40-bit frame sync.
// Optional QPSK_DEMOD_ERRCNT_EN adds a saturating sync_err_cnt output.
module qpsk_demod #(
  parameter int unsigned SPS       = 64,
  parameter int unsigned CAR_PHASE = 0,
  parameter int unsigned SYM_OFS   = 0,
  parameter logic [7:0]  HEAD      = 8'hFF,
  parameter logic [7:0]  TAIL      = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [32:0] qpsk_in,
  output logic [1:0]  dibit,
  output logic        dibit_valid,
  output logic [39:0] para_out,
  output logic        frame_valid,
  output logic        locked
`ifdef QPSK_DEMOD_ERRCNT_EN
  ,
  output logic [15:0] sync_err_cnt
`endif
);

  localparam int unsigned ACC_W        = 34 + $clog2(SPS);
  localparam int unsigned CNT_W        = $clog2(SPS);
  localparam logic [4:0]  FRAME_DIBITS = 5'd20;

  typedef enum logic {S_HUNT, S_LOCK} state_t;

  logic [1:0]              r_phase;
  logic [CNT_W-1:0]        r_sym_cnt;
  logic signed [ACC_W-1:0] r_acc_i;
  logic signed [ACC_W-1:0] r_acc_q;
  logic signed [ACC_W-1:0] w_smp;
  logic signed [ACC_W-1:0] w_sum_i;
  logic signed [ACC_W-1:0] w_sum_q;
  logic                    w_sym_last;
  logic                    w_dec_i;
  logic                    w_dec_q;

  // Top two bits of the 40-bit shift register leave on the next shift, so only 38 are stored.
  logic [37:0]             r_sr;
  logic [39:0]             w_sr_shift;
  logic                    w_match;
  logic [4:0]              r_dcnt;
  logic [4:0]              w_dcnt_inc;
  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [4:0]              w_dcnt_nxt;
  logic [39:0]             w_para_nxt;
  logic                    w_fv_nxt;

  // Mixer: multiply by cos/sin in {+1,0,-1} reduces to add, subtract or hold.
  always_comb begin
    w_smp   = ACC_W'($signed(qpsk_in));
    w_sum_i = r_acc_i;
    w_sum_q = r_acc_q;
    unique case (r_phase)
      2'd0:    w_sum_i = r_acc_i + w_smp;
      2'd1:    w_sum_q = r_acc_q + w_smp;
      2'd2:    w_sum_i = r_acc_i - w_smp;
      default: w_sum_q = r_acc_q - w_smp;
    endcase
  end

  assign w_sym_last = (r_sym_cnt == CNT_W'(SPS - 1));
  assign w_dec_i    = !w_sum_i[ACC_W-1] && (w_sum_i != '0);
  assign w_dec_q    = !w_sum_q[ACC_W-1] && (w_sum_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase     <= 2'(CAR_PHASE);
      r_sym_cnt   <= CNT_W'(SYM_OFS);
      r_acc_i     <= '0;
      r_acc_q     <= '0;
      dibit       <= 2'b00;
      dibit_valid <= 1'b0;
    end else begin
      r_phase     <= r_phase + 2'd1;
      dibit_valid <= w_sym_last;
      if (w_sym_last) begin
        r_sym_cnt <= '0;
        r_acc_i   <= '0;
        r_acc_q   <= '0;
        dibit     <= {w_dec_i, w_dec_q};
      end else begin
        r_sym_cnt <= r_sym_cnt + CNT_W'(1);
        r_acc_i   <= w_sum_i;
        r_acc_q   <= w_sum_q;
      end
    end
  end

  assign w_sr_shift = {r_sr, dibit};
  assign w_match    = (w_sr_shift[39:32] == HEAD) && (w_sr_shift[7:0] == TAIL);
  assign w_dcnt_inc = r_dcnt + 5'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_HUNT;
    else        r_state <= w_state_nxt;
  end

  // Frame sync: hunt on every shift, then only re-check at 20-dibit frame boundaries.
  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    w_para_nxt  = para_out;
    w_fv_nxt    = 1'b0;
    if (dibit_valid) begin
      unique case (r_state)
        S_HUNT: begin
          if (w_match) begin
            w_state_nxt = S_LOCK;
            w_para_nxt  = w_sr_shift;
            w_fv_nxt    = 1'b1;
            w_dcnt_nxt  = '0;
          end
        end
        default: begin
          if (w_dcnt_inc == FRAME_DIBITS) begin
            w_dcnt_nxt = '0;
            if (w_match) begin
              w_para_nxt = w_sr_shift;
              w_fv_nxt   = 1'b1;
            end else begin
              w_state_nxt = S_HUNT;
            end
          end else begin
            w_dcnt_nxt = w_dcnt_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr        <= '0;
      r_dcnt      <= '0;
      para_out    <= '0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
    end else begin
      if (dibit_valid) r_sr <= w_sr_shift[37:0];
      r_dcnt      <= w_dcnt_nxt;
      para_out    <= w_para_nxt;
      frame_valid <= w_fv_nxt;
      locked      <= (w_state_nxt == S_LOCK);
    end
  end

`ifdef QPSK_DEMOD_ERRCNT_EN
  logic        w_sync_err;
  logic [15:0] r_err_cnt;

  assign w_sync_err = dibit_valid && (r_state == S_LOCK) &&
                      (w_dcnt_inc == FRAME_DIBITS) && !w_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_err_cnt <= '0;
    else if (w_sync_err && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
  end

  assign sync_err_cnt = r_err_cnt;
`endif

endmodule
